// File: rtl/store_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor_if
// Brief    : Store bus, trace-FIFO read port and verdict signals of store_monitor.
// Revision : 1.0
// ============================================================================
interface store_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               MemWrite;
    logic [31:0]        Adr;
    logic [31:0]        WriteData;
    logic               rd_en;
    logic [63:0]        rd_data;
    logic               rd_valid;
    logic [c_cnt_w-1:0] count;
    logic               done;
    logic               pass;
    logic               fail;
    logic               timeout;
    logic               overflow;

    modport master (
        output MemWrite, Adr, WriteData, rd_en,
        input  rd_data, rd_valid, count, done, pass, fail, timeout, overflow
    );

    modport slave (
        input  MemWrite, Adr, WriteData, rd_en,
        output rd_data, rd_valid, count, done, pass, fail, timeout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor
// Brief    : Traces processor stores into a FIFO and decides PASS/FAIL/TIMEOUT.
// Revision : 1.0
// ============================================================================
module store_monitor #(
    parameter logic [31:0] PASS_ADDR    = 32'd128,
    parameter logic [31:0] PASS_DATA    = 32'd254,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80,
    parameter int          DEPTH        = 8,
    parameter int          TIMEOUT      = 1024
) (
    input  wire logic      clk,
    input  wire logic      reset,
    store_monitor_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_tmr_w = $clog2(TIMEOUT) + 1;

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_tmr_w-1:0]   r_cycles;
    logic [63:0]          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr;

    // ------------------------------------------------------------------------
    // Verdict FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cycles <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_RUN) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    // A terminal store on the timeout boundary takes priority over TIMEOUT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_RUN;
            S_RUN: begin
                if (bus.MemWrite && (bus.Adr == PASS_ADDR)) begin
                    if (bus.WriteData == PASS_DATA) begin
                        w_next = S_PASS;
                    end else begin
                        w_next = S_FAIL;
                    end
                end else if (bus.MemWrite && (bus.Adr != SCRATCH_ADDR)) begin
                    w_next = S_FAIL;
                end else if (r_cycles == c_tmr_last) begin
                    w_next = S_TIMEOUT;
                end
            end
            default: w_next = r_state;
        endcase
    end

    assign bus.pass    = (r_state == S_PASS);
    assign bus.fail    = (r_state == S_FAIL);
    assign bus.timeout = (r_state == S_TIMEOUT);
    assign bus.done    = bus.pass | bus.fail | bus.timeout;

    // ------------------------------------------------------------------------
    // Trace FIFO
    // ------------------------------------------------------------------------
    // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
    // that the same-cycle push then uses.
    assign w_push = (r_state == S_RUN) && bus.MemWrite;
    assign w_pop  = bus.rd_en && (r_count != '0);
    assign w_wr   = w_push && ((r_count != c_full) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {bus.Adr, bus.WriteData};
        end
    end

    assign bus.rd_data  = r_mem[r_rd_ptr];
    assign bus.rd_valid = (r_count != '0);
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_monitor
// Brief    : Directed and randomized checks of store_monitor against a queue model.
// Revision : 1.0
// ============================================================================
module tb_store_monitor;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_monitor_if #(.DEPTH(DEPTH)) bus();

    store_monitor #(
        .PASS_ADDR   (32'd128),
        .PASS_DATA   (32'd254),
        .SCRATCH_ADDR(32'd80),
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Model: phase 0 idle, 1 run, 2 pass, 3 fail, 4 timeout.
    int          m_phase = 0;
    int          m_cyc   = 0;
    bit          m_ovf   = 1'b0;
    bit          m_init  = 1'b0;
    bit          m_push;
    bit          m_pop;
    logic [63:0] m_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_cyc   = 0;
            m_ovf   = 1'b0;
            m_init  = 1'b1;
            m_q.delete();
        end else begin
            m_pop  = bus.rd_en && (m_q.size() > 0);
            m_push = (m_phase == 1) && bus.MemWrite;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back({bus.Adr, bus.WriteData});
                else m_ovf = 1'b1;
            end
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (bus.MemWrite && bus.Adr == 32'd128)
                    m_phase = (bus.WriteData == 32'd254) ? 2 : 3;
                else if (bus.MemWrite && bus.Adr != 32'd80)
                    m_phase = 3;
                else if (m_cyc == TIMEOUT - 1)
                    m_phase = 4;
                m_cyc++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check("pass",     64'(bus.pass),     64'(m_phase == 2));
            check("fail",     64'(bus.fail),     64'(m_phase == 3));
            check("timeout",  64'(bus.timeout),  64'(m_phase == 4));
            check("done",     64'(bus.done),     64'(m_phase >= 2));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
            check("count",    64'(bus.count),    64'(m_q.size()));
            check("rd_valid", 64'(bus.rd_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) check("rd_data", bus.rd_data, m_q[0]);
        end
    end

    task automatic drive(input logic rs, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic re);
        @(negedge clk);
        reset         = rs;
        bus.MemWrite  = we;
        bus.Adr       = a;
        bus.WriteData = d;
        bus.rd_en     = re;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Two reset cycles then the IDLE->RUN edge; next drive lands on RUN.
    task automatic do_reset();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    int          n;
    int          sel;
    int          wprob;
    logic        we;
    logic        rs;
    logic [31:0] a;
    logic [31:0] d;

    initial begin
        bus.MemWrite = 1'b0; bus.Adr = '0; bus.WriteData = '0; bus.rd_en = 1'b0;

        // Scratch stores then a passing store; drain in order.
        do_reset();
        check("rst_count", 64'(bus.count), 64'd0);
        drive(1'b0, 1'b1, 32'd80, 32'd7, 1'b0);
        drive(1'b0, 1'b1, 32'd80, 32'd9, 1'b0);
        drive(1'b0, 1'b1, 32'd128, 32'd254, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("t1_pass", 64'(bus.pass), 64'd1);
        check("t1_fail", 64'(bus.fail), 64'd0);
        check("t1_count", 64'(bus.count), 64'd3);
        check("t1_head0", bus.rd_data, {32'd80, 32'd7});
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("t1_head1", bus.rd_data, {32'd80, 32'd9});
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("t1_head2", bus.rd_data, {32'd128, 32'd254});
        idle(1);
        check("t1_empty", 64'(bus.rd_valid), 64'd0);

        // Illegal address, then an ignored late store.
        do_reset();
        drive(1'b0, 1'b1, 32'd100, 32'd5, 1'b0);
        drive(1'b0, 1'b1, 32'd128, 32'd254, 1'b0);
        check("t2_fail", 64'(bus.fail), 64'd1);
        check("t2_done", 64'(bus.done), 64'd1);
        idle(1);
        check("t2_pass", 64'(bus.pass), 64'd0);
        check("t2_count", 64'(bus.count), 64'd1);

        // Wrong value at PASS_ADDR.
        do_reset();
        drive(1'b0, 1'b1, 32'd128, 32'd253, 1'b0);
        idle(1);
        check("t3_fail", 64'(bus.fail), 64'd1);
        check("t3_pass", 64'(bus.pass), 64'd0);

        // Timeout after exactly TIMEOUT run cycles.
        do_reset();
        idle(TIMEOUT);
        check("t4_before", 64'(bus.timeout), 64'd0);
        idle(1);
        check("t4_timeout", 64'(bus.timeout), 64'd1);

        // Passing store on the boundary cycle wins.
        do_reset();
        idle(TIMEOUT - 1);
        drive(1'b0, 1'b1, 32'd128, 32'd254, 1'b0);
        idle(1);
        check("t4b_pass", 64'(bus.pass), 64'd1);
        check("t4b_timeout", 64'(bus.timeout), 64'd0);

        // Overflow, full push+pop, pop while empty.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'd80, 32'(i), 1'b0);
        idle(1);
        check("t5_count", 64'(bus.count), 64'd4);
        check("t5_ovf", 64'(bus.overflow), 64'd1);
        check("t5_head", bus.rd_data, {32'd80, 32'd0});
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'd80, 32'(10 + i), 1'b1);
        idle(1);
        check("t5_count_pp", 64'(bus.count), 64'd4);
        check("t5_ovf_pp", 64'(bus.overflow), 64'd1);
        check("t5_head_pp", bus.rd_data, {32'd80, 32'd10});
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(1);
        check("t5_count_e", 64'(bus.count), 64'd0);

        // Reset after PASS with three entries held.
        do_reset();
        drive(1'b0, 1'b1, 32'd80, 32'd1, 1'b0);
        drive(1'b0, 1'b1, 32'd80, 32'd2, 1'b0);
        drive(1'b0, 1'b1, 32'd128, 32'd254, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("t6_pre", 64'(bus.count), 64'd3);
        idle(1);
        check("t6_outs", {bus.pass, bus.fail, bus.timeout, bus.done, bus.overflow,
                          bus.rd_valid, 58'(bus.count)}, 64'd0);
        drive(1'b0, 1'b1, 32'd128, 32'd254, 1'b0);
        idle(1);
        check("t6_fresh", 64'(bus.pass), 64'd1);

        // Randomized runs, checked cycle by cycle against the model.
        for (int r = 0; r < 30; r++) begin
            do_reset();
            n     = $urandom_range(5, 40);
            wprob = r % 3;
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 9);
                we  = (wprob == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, wprob) != 0);
                if (sel < 6)      a = 32'd80;
                else if (sel < 9) a = 32'd128;
                else              a = $urandom;
                d  = (a == 32'd128 && $urandom_range(0, 3) != 0) ? 32'd254 : $urandom;
                rs = ($urandom_range(0, 40) == 0);
                drive(rs, we, a, d, 1'($urandom_range(0, 2) == 0));
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable watcher placed directly downstream of the processor top's memory bus (MemWrite, Adr, WriteData).
- Records every store into a small trace FIFO and decides the run verdict in hardware:
  - PASS on a write of PASS_DATA to PASS_ADDR.
  - FAIL on a write to any address other than PASS_ADDR or SCRATCH_ADDR, or on a wrong value at PASS_ADDR.
  - TIMEOUT when no verdict is reached within TIMEOUT cycles.
- Lets the FPGA build and regression benches share one pass/fail mechanism.

Parameters:
- PASS_ADDR, 32'd128, address whose store ends the run.
- PASS_DATA, 32'd254, value required at PASS_ADDR for PASS.
- SCRATCH_ADDR, 32'd80, the only other address that may be written without failing.
- DEPTH, 8, trace FIFO entries; power of two, ≥2.
- TIMEOUT, 1024, cycles allowed in RUN before TIMEOUT; ≥2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store strobe from the processor top.
- Adr  input  32  store address.
- WriteData  input  32  store data.
- rd_en  input  1  pop the head trace entry.
- rd_data  output  64  head entry, {Adr, WriteData}; first-word-fall-through.
- rd_valid  output  1  FIFO non-empty.
- count  output  $clog2(DEPTH)+1  number of entries held.
- done  output  1  verdict reached (PASS, FAIL or TIMEOUT).
- pass  output  1  state == PASS.
- fail  output  1  state == FAIL.
- timeout  output  1  state == TIMEOUT.
- overflow  output  1  sticky; a store was dropped because the FIFO was full.

Behaviour:
- Reset: state=IDLE, FIFO pointers=0, count=0, cycle counter=0, overflow=0, done/pass/fail/timeout=0, rd_valid=0. rd_data is don't-care while rd_valid=0.
- IDLE: moves to RUN on the first clock with reset=0; no stores are sampled in that cycle.
- RUN, per rising edge:
  - Cycle counter increments.
  - If MemWrite=1, the store is pushed to the FIFO and classified:
    - Adr==PASS_ADDR and WriteData==PASS_DATA → PASS.
    - Adr==PASS_ADDR with any other data → FAIL.
    - Adr==SCRATCH_ADDR → stay in RUN.
    - Any other address → FAIL.
  - If no terminal store occurs and the counter equals TIMEOUT-1 → TIMEOUT.
  - A terminal store in the same cycle as the timeout boundary wins; the verdict is PASS or FAIL, not TIMEOUT.
- PASS/FAIL/TIMEOUT: terminal and sticky until reset. Later stores are neither classified nor pushed. FIFO reads still work.
- Verdict timing: verdict outputs are registered; they assert the cycle after the deciding edge. done = pass|fail|timeout.
- FIFO push/pop:
  - Push happens only in RUN with MemWrite=1, including the terminal store.
  - Full (count==DEPTH), push without pop: the entry is dropped and overflow is set. The verdict is still computed.
  - Full, push and pop in the same cycle: both happen; count stays DEPTH; no overflow.
  - Empty, push and pop in the same cycle: the pop is ignored; the push is accepted; count becomes 1.
  - Empty, rd_en=1 alone: ignored; count stays 0.
  - Pointers wrap modulo DEPTH. count changes by exactly +1, −1 or 0 per cycle.
- Reset mid-run, or after a verdict: all state clears as above on that edge, including FIFO contents (count=0) and overflow.
- X on the inputs is outside this block's scope; the bench keeps its own X check on Instr.

Test Plan:
- Reset for 2 cycles, then stores (80,7), (80,9), (128,254) on consecutive cycles → pass=1 one cycle after the third store. fail=0, count=3. Pops return {80,7}, {80,9}, {128,254}, then rd_valid=0.
- Store (100,5) in RUN → fail=1 next cycle, done=1. A later store (128,254) leaves pass=0 and count=1.
- Store (128,253) → fail=1, pass=0.
- No stores with TIMEOUT=16 → timeout=1 exactly 16 RUN cycles after entering RUN. Repeat with (128,254) on the boundary cycle → pass=1, timeout=0.
- DEPTH=4: five stores to 80 with no pops → count=4, overflow=1, and the head is still the first store. Then 4 pops with simultaneous push each cycle → count stays 4, overflow unchanged. Then pop while empty → count=0.
- Assert reset after a PASS with count=3 → next cycle all outputs are 0. After release, the block behaves as a fresh run.
